// File: rtl/alu_reservation_station.sv
// ALU reservation station for a Tomasulo core.
// Holds dispatched ALU ops until both operands are available, snoops the CDB
// for missing operands, issues the lowest ready entry to a single-cycle LC-3b
// ALU and keeps the result in a register until the CDB arbiter grants it.
module alu_reservation_station #(
    parameter int NUM_ENTRIES = 3,
    parameter int TAG_WIDTH   = 3,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  dispatch_valid,
    input  logic [2:0]            dispatch_op,
    input  logic [TAG_WIDTH-1:0]  dispatch_dest,
    input  logic [DATA_WIDTH-1:0] dispatch_vj,
    input  logic [DATA_WIDTH-1:0] dispatch_vk,
    input  logic [TAG_WIDTH-1:0]  dispatch_qj,
    input  logic [TAG_WIDTH-1:0]  dispatch_qk,
    input  logic                  dispatch_rj,
    input  logic                  dispatch_rk,
    output logic                  full,
    input  logic                  cdb_valid,
    input  logic [TAG_WIDTH-1:0]  cdb_tag,
    input  logic [DATA_WIDTH-1:0] cdb_data,
    output logic                  result_valid,
    output logic [TAG_WIDTH-1:0]  result_tag,
    output logic [DATA_WIDTH-1:0] result_data,
    input  logic                  result_grant
);

    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    logic [NUM_ENTRIES-1:0] busy_q, busy_d;
    logic [NUM_ENTRIES-1:0] rj_q, rj_d;
    logic [NUM_ENTRIES-1:0] rk_q, rk_d;
    logic [2:0]             op_q   [NUM_ENTRIES];
    logic [2:0]             op_d   [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]   dest_q [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]   dest_d [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]   qj_q   [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]   qj_d   [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]   qk_q   [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]   qk_d   [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]  vj_q   [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]  vj_d   [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]  vk_q   [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]  vk_d   [NUM_ENTRIES];

    logic                   res_valid_q, res_valid_d;
    logic [TAG_WIDTH-1:0]   res_tag_q, res_tag_d;
    logic [DATA_WIDTH-1:0]  res_data_q, res_data_d;

    logic [NUM_ENTRIES-1:0] ready;
    logic                   any_ready;
    logic                   any_free;
    logic [IDX_W-1:0]       issue_idx;
    logic [IDX_W-1:0]       free_idx;
    logic                   issue_en;
    logic                   dispatch_accept;

    // LC-3b ALU; the low four bits of b are the shift amount.
    function automatic logic [DATA_WIDTH-1:0] aluCompute(
        input logic [2:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [3:0] shamt;
        shamt = b[3:0];
        case (op)
            3'd0:    aluCompute = a + b;
            3'd1:    aluCompute = a & b;
            3'd2:    aluCompute = ~a;
            3'd3:    aluCompute = b;
            3'd4:    aluCompute = a << shamt;
            3'd5:    aluCompute = a >> shamt;
            3'd6:    aluCompute = DATA_WIDTH'($signed(a) >>> shamt);
            default: aluCompute = '0;
        endcase
    endfunction

    // Lowest-index ready entry for issue and lowest-index free slot for dispatch.
    // Only registered busy bits are used, so a slot freed by issue this cycle
    // cannot be refilled until the next cycle.
    always_comb begin
        ready     = busy_q & rj_q & rk_q;
        any_ready = |ready;
        any_free  = ~(&busy_q);
        issue_idx = '0;
        free_idx  = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (ready[i]) begin
                issue_idx = IDX_W'(i);
            end
            if (!busy_q[i]) begin
                free_idx = IDX_W'(i);
            end
        end
        full            = ~any_free;
        issue_en        = any_ready && (!res_valid_q || result_grant);
        dispatch_accept = dispatch_valid && any_free && !flush;
    end

    // Next-state: CDB snoop, issue into the result register, dispatch, then flush overrides.
    always_comb begin
        busy_d      = busy_q;
        rj_d        = rj_q;
        rk_d        = rk_q;
        op_d        = op_q;
        dest_d      = dest_q;
        qj_d        = qj_q;
        qk_d        = qk_q;
        vj_d        = vj_q;
        vk_d        = vk_q;
        res_valid_d = res_valid_q;
        res_tag_d   = res_tag_q;
        res_data_d  = res_data_q;

        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (busy_q[i] && cdb_valid) begin
                if (!rj_q[i] && (qj_q[i] == cdb_tag)) begin
                    vj_d[i] = cdb_data;
                    rj_d[i] = 1'b1;
                end
                if (!rk_q[i] && (qk_q[i] == cdb_tag)) begin
                    vk_d[i] = cdb_data;
                    rk_d[i] = 1'b1;
                end
            end
        end

        if (issue_en) begin
            busy_d[issue_idx] = 1'b0;
            res_valid_d       = 1'b1;
            res_tag_d         = dest_q[issue_idx];
            res_data_d        = aluCompute(op_q[issue_idx], vj_q[issue_idx], vk_q[issue_idx]);
        end else if (res_valid_q && result_grant) begin
            res_valid_d = 1'b0;
        end

        if (dispatch_accept) begin
            busy_d[free_idx] = 1'b1;
            op_d[free_idx]   = dispatch_op;
            dest_d[free_idx] = dispatch_dest;
            qj_d[free_idx]   = dispatch_qj;
            qk_d[free_idx]   = dispatch_qk;
            if (!dispatch_rj && cdb_valid && (cdb_tag == dispatch_qj)) begin
                vj_d[free_idx] = cdb_data;
                rj_d[free_idx] = 1'b1;
            end else begin
                vj_d[free_idx] = dispatch_vj;
                rj_d[free_idx] = dispatch_rj;
            end
            if (!dispatch_rk && cdb_valid && (cdb_tag == dispatch_qk)) begin
                vk_d[free_idx] = cdb_data;
                rk_d[free_idx] = 1'b1;
            end else begin
                vk_d[free_idx] = dispatch_vk;
                rk_d[free_idx] = dispatch_rk;
            end
        end

        if (flush) begin
            busy_d      = '0;
            res_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q      <= '0;
            rj_q        <= '0;
            rk_q        <= '0;
            res_valid_q <= 1'b0;
            res_tag_q   <= '0;
            res_data_q  <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                op_q[i]   <= '0;
                dest_q[i] <= '0;
                qj_q[i]   <= '0;
                qk_q[i]   <= '0;
                vj_q[i]   <= '0;
                vk_q[i]   <= '0;
            end
        end else begin
            busy_q      <= busy_d;
            rj_q        <= rj_d;
            rk_q        <= rk_d;
            res_valid_q <= res_valid_d;
            res_tag_q   <= res_tag_d;
            res_data_q  <= res_data_d;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                op_q[i]   <= op_d[i];
                dest_q[i] <= dest_d[i];
                qj_q[i]   <= qj_d[i];
                qk_q[i]   <= qk_d[i];
                vj_q[i]   <= vj_d[i];
                vk_q[i]   <= vk_d[i];
            end
        end
    end

    assign result_valid = res_valid_q;
    assign result_tag   = res_tag_q;
    assign result_data  = res_data_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed testbench for alu_reservation_station with hand-computed expectations.
module tb_alu_reservation_station;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        dispatch_valid;
    logic [2:0]  dispatch_op;
    logic [2:0]  dispatch_dest;
    logic [15:0] dispatch_vj;
    logic [15:0] dispatch_vk;
    logic [2:0]  dispatch_qj;
    logic [2:0]  dispatch_qk;
    logic        dispatch_rj;
    logic        dispatch_rk;
    logic        full;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        result_valid;
    logic [2:0]  result_tag;
    logic [15:0] result_data;
    logic        result_grant;

    int checks   = 0;
    int failures = 0;

    alu_reservation_station #(
        .NUM_ENTRIES(3),
        .TAG_WIDTH(3),
        .DATA_WIDTH(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .dispatch_valid(dispatch_valid),
        .dispatch_op(dispatch_op),
        .dispatch_dest(dispatch_dest),
        .dispatch_vj(dispatch_vj),
        .dispatch_vk(dispatch_vk),
        .dispatch_qj(dispatch_qj),
        .dispatch_qk(dispatch_qk),
        .dispatch_rj(dispatch_rj),
        .dispatch_rk(dispatch_rk),
        .full(full),
        .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag),
        .cdb_data(cdb_data),
        .result_valid(result_valid),
        .result_tag(result_tag),
        .result_data(result_data),
        .result_grant(result_grant)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [2:0] dest,
                                 input logic [15:0] vj, input logic [15:0] vk,
                                 input logic [2:0] qj, input logic [2:0] qk,
                                 input logic rj, input logic rk);
        dispatch_valid = 1'b1;
        dispatch_op    = op;
        dispatch_dest  = dest;
        dispatch_vj    = vj;
        dispatch_vk    = vk;
        dispatch_qj    = qj;
        dispatch_qk    = qk;
        dispatch_rj    = rj;
        dispatch_rk    = rk;
    endtask

    task automatic idleDispatch();
        dispatch_valid = 1'b0;
    endtask

    // Directed sequence covering reset, issue, snoop, back-pressure, forwarding, flush and async reset.
    initial begin
        reset = 1'b1; flush = 1'b0; result_grant = 1'b0;
        dispatch_valid = 1'b0; dispatch_op = '0; dispatch_dest = '0;
        dispatch_vj = '0; dispatch_vk = '0; dispatch_qj = '0; dispatch_qk = '0;
        dispatch_rj = 1'b0; dispatch_rk = 1'b0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        repeat (2) step();
        reset = 1'b0;
        step();

        $display("[TB] reset state");
        checkOutput("reset_valid", 32'(result_valid), 32'd0);
        checkOutput("reset_tag", 32'(result_tag), 32'd0);
        checkOutput("reset_data", 32'(result_data), 32'd0);
        checkOutput("reset_full", 32'(full), 32'd0);

        $display("[TB] single ADD latency");
        result_grant = 1'b1;
        applyStimulus(3'd0, 3'd2, 16'h0005, 16'h0003, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        idleDispatch();
        checkOutput("add_not_yet", 32'(result_valid), 32'd0);
        step();
        checkOutput("add_valid", 32'(result_valid), 32'd1);
        checkOutput("add_tag", 32'(result_tag), 32'd2);
        checkOutput("add_data", 32'(result_data), 32'h0008);
        step();
        checkOutput("add_drop", 32'(result_valid), 32'd0);

        $display("[TB] CDB snoop");
        applyStimulus(3'd1, 3'd1, 16'h0000, 16'h00F0, 3'd4, 3'd0, 1'b0, 1'b1);
        step();
        idleDispatch();
        cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 16'h1234;
        step();
        checkOutput("snoop_wrong_tag", 32'(result_valid), 32'd0);
        cdb_tag = 3'd4; cdb_data = 16'h0FFF;
        step();
        cdb_valid = 1'b0;
        checkOutput("snoop_no_bypass", 32'(result_valid), 32'd0);
        step();
        checkOutput("snoop_valid", 32'(result_valid), 32'd1);
        checkOutput("snoop_tag", 32'(result_tag), 32'd1);
        checkOutput("snoop_data", 32'(result_data), 32'h00F0);
        step();
        checkOutput("snoop_drop", 32'(result_valid), 32'd0);

        $display("[TB] back-pressure and back-to-back issue");
        result_grant = 1'b0;
        applyStimulus(3'd0, 3'd3, 16'h0001, 16'h0001, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        checkOutput("bp_first_wait", 32'(result_valid), 32'd0);
        applyStimulus(3'd3, 3'd4, 16'h0000, 16'h1111, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        checkOutput("bp_first_valid", 32'(result_valid), 32'd1);
        checkOutput("bp_first_data", 32'(result_data), 32'h0002);
        applyStimulus(3'd2, 3'd5, 16'h00FF, 16'h0000, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        checkOutput("bp_two_busy_full", 32'(full), 32'd0);
        applyStimulus(3'd4, 3'd6, 16'h0001, 16'h0004, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        checkOutput("bp_full", 32'(full), 32'd1);
        applyStimulus(3'd0, 3'd7, 16'h0009, 16'h0009, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        idleDispatch();
        checkOutput("bp_full_hold", 32'(full), 32'd1);
        checkOutput("bp_hold_valid", 32'(result_valid), 32'd1);
        checkOutput("bp_hold_tag", 32'(result_tag), 32'd3);
        checkOutput("bp_hold_data", 32'(result_data), 32'h0002);
        result_grant = 1'b1;
        step();
        checkOutput("b2b_e0_valid", 32'(result_valid), 32'd1);
        checkOutput("b2b_e0_tag", 32'(result_tag), 32'd5);
        checkOutput("b2b_e0_data", 32'(result_data), 32'hFF00);
        checkOutput("b2b_not_full", 32'(full), 32'd0);
        step();
        checkOutput("b2b_e1_valid", 32'(result_valid), 32'd1);
        checkOutput("b2b_e1_tag", 32'(result_tag), 32'd4);
        checkOutput("b2b_e1_data", 32'(result_data), 32'h1111);
        step();
        checkOutput("b2b_e2_valid", 32'(result_valid), 32'd1);
        checkOutput("b2b_e2_tag", 32'(result_tag), 32'd6);
        checkOutput("b2b_e2_data", 32'(result_data), 32'h0010);
        step();
        checkOutput("b2b_dropped_dispatch", 32'(result_valid), 32'd0);

        $display("[TB] dispatch forwarding and shifts");
        applyStimulus(3'd6, 3'd7, 16'h8000, 16'h5555, 3'd0, 3'd3, 1'b1, 1'b0);
        cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 16'h8000;
        step();
        idleDispatch();
        cdb_valid = 1'b0;
        step();
        checkOutput("fwd_valid", 32'(result_valid), 32'd1);
        checkOutput("fwd_tag", 32'(result_tag), 32'd7);
        checkOutput("fwd_rshfa0_data", 32'(result_data), 32'h8000);
        applyStimulus(3'd6, 3'd1, 16'h8000, 16'h0004, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        idleDispatch();
        step();
        checkOutput("rshfa4_data", 32'(result_data), 32'hF800);
        applyStimulus(3'd5, 3'd2, 16'h8000, 16'h0004, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        idleDispatch();
        step();
        checkOutput("rshfl4_data", 32'(result_data), 32'h0800);
        applyStimulus(3'd0, 3'd3, 16'hFFFF, 16'h0001, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        idleDispatch();
        step();
        checkOutput("add_wrap_data", 32'(result_data), 32'h0000);
        applyStimulus(3'd7, 3'd4, 16'h1234, 16'h5678, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        idleDispatch();
        step();
        checkOutput("op7_tag", 32'(result_tag), 32'd4);
        checkOutput("op7_data", 32'(result_data), 32'h0000);
        step();

        $display("[TB] flush");
        result_grant = 1'b0;
        applyStimulus(3'd0, 3'd1, 16'h0002, 16'h0002, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        idleDispatch();
        step();
        applyStimulus(3'd1, 3'd2, 16'hFFFF, 16'h0F0F, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        applyStimulus(3'd2, 3'd3, 16'h1234, 16'h0000, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        checkOutput("flush_pre_valid", 32'(result_valid), 32'd1);
        checkOutput("flush_pre_data", 32'(result_data), 32'h0004);
        flush = 1'b1;
        result_grant = 1'b1;
        applyStimulus(3'd3, 3'd5, 16'h0000, 16'hABCD, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        flush = 1'b0;
        idleDispatch();
        checkOutput("flush_full", 32'(full), 32'd0);
        checkOutput("flush_valid", 32'(result_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("flush_no_result", 32'(result_valid), 32'd0);
        end

        $display("[TB] asynchronous reset");
        result_grant = 1'b0;
        applyStimulus(3'd0, 3'd1, 16'h0001, 16'h0002, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        applyStimulus(3'd0, 3'd2, 16'h0003, 16'h0004, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        applyStimulus(3'd0, 3'd3, 16'h0005, 16'h0006, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        applyStimulus(3'd0, 3'd4, 16'h0007, 16'h0008, 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        idleDispatch();
        checkOutput("areset_pre_full", 32'(full), 32'd1);
        checkOutput("areset_pre_valid", 32'(result_valid), 32'd1);
        checkOutput("areset_pre_data", 32'(result_data), 32'h0003);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("areset_valid", 32'(result_valid), 32'd0);
        checkOutput("areset_full", 32'(full), 32'd0);
        checkOutput("areset_tag", 32'(result_tag), 32'd0);
        checkOutput("areset_data", 32'(result_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        result_grant = 1'b1;
        step();
        checkOutput("areset_post_valid", 32'(result_valid), 32'd0);
        checkOutput("areset_post_full", 32'(full), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
